// File: rtl/onehot_encoder_pkg.sv
// Shared sizing defaults and FSM state encoding for the one-hot encoder.
// Combinational only; no latency and no backpressure of its own.
package onehot_encoder_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int IDX_W_DEF = 5;
  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

endpackage

// File: rtl/onehot_encoder_if.sv
// Write-enable vector in, binary index beats out, with valid/ready on both sides.
// Wires only; latency and backpressure are defined by the encoder driving the slave side.
interface onehot_encoder_if
  import onehot_encoder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic             out_last;
  logic             out_multi;
  logic             zero_err;
  logic [CNT_W-1:0] multi_count;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_index, out_last, out_multi, zero_err, multi_count
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_index, out_last, out_multi, zero_err, multi_count
  );

endinterface

// File: rtl/onehot_encoder_lsb_priority_enc.sv
// Lowest-set-bit index plus an exactly-one-bit-set flag for the pending vector.
// Purely combinational, zero latency; an all-zero vector yields index 0 and single=0.
module lsb_priority_enc
  import onehot_encoder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             single
);

  logic [WIDTH-1:0] vec_minus_one;

  assign vec_minus_one = vec - WIDTH'(1);

  always_comb begin
    idx = '0;
    // Scan downward so the lowest set bit is the last (winning) assignment.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

  assign single = (|vec) && !(|(vec & vec_minus_one));

endmodule

// File: rtl/onehot_encoder.sv
// Splits a multi-hot write-enable vector into ascending binary index beats, one per handshake.
// Latency 1 from accept to first beat; in_ready drops while beats remain and reopens on the last beat.
module onehot_encoder
  import onehot_encoder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  onehot_encoder_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             multi_q, multi_d;
  logic             zero_err_q, zero_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] lsb_idx;
  logic             lsb_single;
  logic             out_vld;
  logic             out_fire;
  logic             in_rdy;
  logic             accept;
  logic             vec_nonzero;
  logic             vec_multi;

  lsb_priority_enc #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_lsb_enc (
    .vec    (pend_q),
    .idx    (lsb_idx),
    .single (lsb_single)
  );

  assign out_vld     = (state_q == EMIT);
  assign out_fire    = out_vld && bus.out_ready;
  // Back-to-back accept is only allowed while the final beat is leaving.
  assign in_rdy      = (state_q == IDLE) || (out_fire && lsb_single);
  assign accept      = bus.in_valid && in_rdy;
  assign vec_nonzero = |bus.in_vec;
  assign vec_multi   = |(bus.in_vec & (bus.in_vec - WIDTH'(1)));

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    multi_d    = multi_q;
    zero_err_d = 1'b0;
    cnt_d      = cnt_q;

    if (out_fire) begin
      pend_d = pend_q & (pend_q - WIDTH'(1));
      if (lsb_single) begin
        state_d = IDLE;
      end
    end

    if (accept) begin
      if (vec_nonzero) begin
        pend_d  = bus.in_vec;
        state_d = EMIT;
        multi_d = vec_multi;
        if (vec_multi && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        zero_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      multi_q    <= 1'b0;
      zero_err_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      multi_q    <= multi_d;
      zero_err_q <= zero_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready    = in_rdy;
  assign bus.out_valid   = out_vld;
  assign bus.out_index   = lsb_idx;
  assign bus.out_last    = out_vld && lsb_single;
  assign bus.out_multi   = multi_q;
  assign bus.zero_err    = zero_err_q;
  assign bus.multi_count = cnt_q;

endmodule

// File: tb/tb_onehot_encoder.sv
// Directed bench for onehot_encoder: drives on the falling edge, checks #1 later.
module tb_onehot_encoder;
  import onehot_encoder_pkg::*;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_bad;

  onehot_encoder_if #(.WIDTH(32), .IDX_W(5), .CNT_W(8)) bus ();

  onehot_encoder #(.WIDTH(32), .IDX_W(5), .CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] v;
    logic [4:0]  exp_idx [3];
    logic        exp_last[3];
    int          accepted;
    int          beats;

    n_vec = 0;
    n_bad = 0;
    reset_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b0;

    // Reset values
    repeat (2) step();
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_index", bus.out_index, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_out_multi", bus.out_multi, 0);
    chk("rst_zero_err", bus.zero_err, 0);
    chk("rst_multi_count", bus.multi_count, 0);
    step();
    reset_n = 1'b1;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Single-hot sweep, back-to-back
    bus.out_ready = 1'b1;
    for (int k = 0; k <= 32; k++) begin
      if (k > 0) step();
      if (k < 32) begin
        v = 32'h1 << k;
        bus.in_valid = 1'b1;
        bus.in_vec   = v;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (k < 32) chk("sweep_in_ready", bus.in_ready, 1);
      if (k > 0) begin
        chk("sweep_out_valid", bus.out_valid, 1);
        chk("sweep_out_index", bus.out_index, k - 1);
        chk("sweep_out_last", bus.out_last, 1);
        chk("sweep_out_multi", bus.out_multi, 0);
      end
    end
    step();
    #1;
    chk("sweep_drain_valid", bus.out_valid, 0);
    chk("sweep_multi_count", bus.multi_count, 0);

    // Multi-hot 0x8000_0005
    exp_idx[0] = 5'd0;  exp_last[0] = 1'b0;
    exp_idx[1] = 5'd2;  exp_last[1] = 1'b0;
    exp_idx[2] = 5'd31; exp_last[2] = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_vec   = 32'h8000_0005;
    #1;
    chk("mh_accept_ready", bus.in_ready, 1);
    for (int b = 0; b < 3; b++) begin
      step();
      bus.in_valid = 1'b0;
      #1;
      chk("mh_out_valid", bus.out_valid, 1);
      chk("mh_out_index", bus.out_index, exp_idx[b]);
      chk("mh_out_last", bus.out_last, exp_last[b]);
      chk("mh_out_multi", bus.out_multi, 1);
      chk("mh_in_ready", bus.in_ready, exp_last[b]);
    end
    step();
    #1;
    chk("mh_drain_valid", bus.out_valid, 0);
    chk("mh_multi_count", bus.multi_count, 1);

    // Stall with 0x30
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_vec    = 32'h0000_0030;
    for (int c = 0; c < 4; c++) begin
      step();
      bus.in_valid = 1'b0;
      #1;
      chk("stall_out_valid", bus.out_valid, 1);
      chk("stall_out_index", bus.out_index, 4);
      chk("stall_out_last", bus.out_last, 0);
      chk("stall_out_multi", bus.out_multi, 1);
      chk("stall_in_ready", bus.in_ready, 0);
    end
    step();
    bus.out_ready = 1'b1;
    #1;
    chk("stall_rel_index0", bus.out_index, 4);
    chk("stall_rel_last0", bus.out_last, 0);
    step();
    #1;
    chk("stall_rel_index1", bus.out_index, 5);
    chk("stall_rel_last1", bus.out_last, 1);
    step();
    #1;
    chk("stall_drain_valid", bus.out_valid, 0);
    chk("stall_multi_count", bus.multi_count, 2);

    // All-zero vector
    bus.in_valid = 1'b1;
    bus.in_vec   = 32'h0;
    #1;
    chk("zero_in_ready", bus.in_ready, 1);
    chk("zero_err_before", bus.zero_err, 0);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("zero_err_pulse", bus.zero_err, 1);
    chk("zero_out_valid", bus.out_valid, 0);
    chk("zero_in_ready_after", bus.in_ready, 1);
    step();
    #1;
    chk("zero_err_cleared", bus.zero_err, 0);
    chk("zero_out_valid2", bus.out_valid, 0);
    chk("zero_multi_count", bus.multi_count, 2);

    // Reset in the middle of an all-ones vector
    bus.in_valid = 1'b1;
    bus.in_vec   = 32'hFFFF_FFFF;
    for (int b = 0; b < 10; b++) begin
      step();
      bus.in_valid = 1'b0;
      #1;
      chk("ones_out_index", bus.out_index, b);
      chk("ones_out_last", bus.out_last, 0);
    end
    step();
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_multi_count", bus.multi_count, 0);
    chk("midrst_out_index", bus.out_index, 0);
    step();
    reset_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_vec   = 32'h0000_0002;
    #1;
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_no_leftover", bus.out_valid, 0);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("post_rst_valid", bus.out_valid, 1);
    chk("post_rst_index", bus.out_index, 1);
    chk("post_rst_last", bus.out_last, 1);
    chk("post_rst_multi", bus.out_multi, 0);
    step();
    #1;
    chk("post_rst_drain", bus.out_valid, 0);

    // Saturation: 300 vectors of 0x3
    accepted = 0;
    beats    = 0;
    bus.in_vec = 32'h0000_0003;
    for (int c = 0; c < 2000; c++) begin
      if (c > 0) step();
      bus.in_valid = (accepted < 300);
      #1;
      if (bus.out_valid) begin
        chk("sat_out_index", bus.out_index, beats % 2);
        chk("sat_out_last", bus.out_last, beats % 2);
        beats++;
      end
      if (bus.in_valid && bus.in_ready) accepted++;
      if (accepted == 300 && beats == 600) break;
    end
    chk("sat_accepted", accepted, 300);
    chk("sat_beats", beats, 600);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("sat_multi_count", bus.multi_count, 255);
    chk("sat_drain_valid", bus.out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
